// File: rtl/lab5_isa_pkg.sv
// lab5 ISA constants shared by the fetch sequencer: branch opcodes, HALT encoding, FSM states.
package lab5_isa_pkg;

  localparam logic [3:0]  OP_BEQ   = 4'b1000;
  localparam logic [3:0]  OP_BNE   = 4'b1001;
  localparam logic [3:0]  OP_BGEZ  = 4'b1010;
  localparam logic [3:0]  OP_BLTZ  = 4'b1011;
  localparam logic [15:0] HALT_ENC = 16'h0001;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} state_e;

  function automatic logic is_branch(input logic [15:0] ir);
    logic [3:0] op;
    op = ir[15:12];
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGEZ) || (op == OP_BLTZ);
  endfunction

endpackage

// File: rtl/lab5_branch_target.sv
// Next-PC adder: PC+2, plus the sign-extended word offset (x2) when the branch is taken.
module lab5_branch_target #(
  parameter int AW = 8
) (
  input  logic [AW-1:0] pc_i,
  input  logic [5:0]    off_i,
  input  logic          taken_i,
  output logic [AW-1:0] next_pc_o
);

  logic [AW-1:0] off_bytes;

  // Sign-extend the word offset to AW bits, then scale to bytes; wraps mod 2^AW.
  assign off_bytes = {{(AW-6){off_i[5]}}, off_i} << 1;
  assign next_pc_o = pc_i + AW'(2) + (taken_i ? off_bytes : '0);

endmodule

// File: rtl/lab5_fetch_ctrl.sv
// Fetch/PC sequencer for the lab5 CPU: IDLE -> FETCH -> EXEC loop, branch resolution, HALT.
// Define SINGLE_STEP_EN to add the STEP input (edge-triggered single instruction from IDLE).
module lab5_fetch_ctrl
  import lab5_isa_pkg::*;
#(
  parameter int            AW        = 8,
  parameter logic [AW-1:0] PC_RESET  = 8'h00,
  parameter logic [15:0]   HALT_WORD = HALT_ENC
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          RUN,
`ifdef SINGLE_STEP_EN
  input  logic          STEP,
`endif
  input  logic [15:0]   INSTR,
  input  logic          BR_COND,
  input  logic          DP_STALL,
  output logic [AW-1:0] ADDR,
  output logic [15:0]   IR,
  output logic          IR_VALID,
  output logic          COMMIT,
  output logic          HALTED
);

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] next_pc_d;
  logic [15:0]   ir_q;
  logic          ir_valid_q;
  logic          halted_q;
  logic          start;
  logic          taken;

`ifdef SINGLE_STEP_EN
  logic step_q;
  assign start = RUN || (STEP && !step_q);
`else
  assign start = RUN;
`endif

  assign taken = is_branch(ir_q) && BR_COND;

  lab5_branch_target #(.AW(AW)) u_bt (
    .pc_i      (pc_q),
    .off_i     (ir_q[5:0]),
    .taken_i   (taken),
    .next_pc_o (next_pc_d)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      pc_q       <= PC_RESET;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
`ifdef SINGLE_STEP_EN
      step_q     <= 1'b0;
`endif
    end else begin
`ifdef SINGLE_STEP_EN
      step_q <= STEP;
`endif
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_FETCH;
        end
        S_FETCH: begin
          ir_q       <= INSTR;
          ir_valid_q <= 1'b1;
          state_q    <= S_EXEC;
        end
        S_EXEC: begin
          if (!DP_STALL) begin
            ir_valid_q <= 1'b0;
            if (ir_q == HALT_WORD) begin
              halted_q <= 1'b1;
              state_q  <= S_HALTED;
            end else begin
              pc_q    <= next_pc_d;
              state_q <= RUN ? S_FETCH : S_IDLE;
            end
          end
        end
        S_HALTED: state_q <= S_HALTED;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // COMMIT must coincide with the retiring EXEC cycle, so it is decoded rather than registered.
  assign COMMIT   = (state_q == S_EXEC) && !DP_STALL && !RESET;
  assign ADDR     = {pc_q[AW-1:1], 1'b0};
  assign IR       = ir_q;
  assign IR_VALID = ir_valid_q;
  assign HALTED   = halted_q;

endmodule

// File: tb/tb_lab5_fetch_ctrl.sv
// Directed self-checking bench for lab5_fetch_ctrl; instruction memory modelled as a bench array.
module tb_lab5_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        RUN = 1'b0;
`ifdef SINGLE_STEP_EN
  logic        STEP = 1'b0;
`endif
  logic [15:0] INSTR;
  logic        BR_COND = 1'b0;
  logic        DP_STALL = 1'b0;
  logic [7:0]  ADDR;
  logic [15:0] IR;
  logic        IR_VALID, COMMIT, HALTED;

  logic [15:0] imem [128];
  int n_chk = 0;
  int n_err = 0;
  int commits = 0;
  int c0;

  always #5 CLK = ~CLK;

  assign INSTR = imem[ADDR[7:1]];

  lab5_fetch_ctrl dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN),
`ifdef SINGLE_STEP_EN
    .STEP(STEP),
`endif
    .INSTR(INSTR), .BR_COND(BR_COND), .DP_STALL(DP_STALL),
    .ADDR(ADDR), .IR(IR), .IR_VALID(IR_VALID), .COMMIT(COMMIT), .HALTED(HALTED)
  );

  // Inputs settle 1 time unit after posedge, so the negedge sees the retiring cycle's COMMIT.
  always @(negedge CLK) if (COMMIT === 1'b1) commits <= commits + 1;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill();
    for (int i = 0; i < 128; i++) imem[i] = 16'h5041;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: straight-line program ending in HALT
    fill();
    imem[2] = 16'h0001;
    cyc();
    chk("rst_addr", ADDR, 8'h00);
    chk("rst_ir", IR, 16'h0000);
    chk("rst_irv", IR_VALID, 1'b0);
    chk("rst_commit", COMMIT, 1'b0);
    chk("rst_halted", HALTED, 1'b0);
    RESET = 1'b0;
    RUN = 1'b1;
    c0 = commits;
    cyc(); chk("t1_addr0", ADDR, 8'h00);
    cyc(); chk("t1_ir0", IR, 16'h5041);
    cyc(); chk("t1_addr2", ADDR, 8'h02);
    cyc();
    cyc(); chk("t1_addr4", ADDR, 8'h04);
    cyc(); chk("t1_ir_halt", IR, 16'h0001);
    chk("t1_irv_halt", IR_VALID, 1'b1);
    cyc(); chk("t1_halted", HALTED, 1'b1);
    repeat (3) cyc();
    chk("t1_addr_hold", ADDR, 8'h04);
    chk("t1_halted_hold", HALTED, 1'b1);
    chk("t1_irv_off", IR_VALID, 1'b0);
    chk("t1_commits", commits - c0, 3);
    // 6a: reset out of HALTED
    RESET = 1'b1;
    cyc();
    chk("t6_halt_rst_h", HALTED, 1'b0);
    chk("t6_halt_rst_a", ADDR, 8'h00);
    RESET = 1'b0;

    // 2: BNE at 06, offset -3 words
    fill();
    imem[3] = 16'h903D;
    BR_COND = 1'b1;
    do_reset();
    repeat (7) cyc();
    chk("t2_addr6", ADDR, 8'h06);
    cyc(); chk("t2_ir_bne", IR, 16'h903D);
    cyc(); chk("t2_taken", ADDR, 8'h02);
    BR_COND = 1'b0;
    do_reset();
    repeat (9) cyc();
    chk("t2_not_taken", ADDR, 8'h08);

    // 3: wrap FE->00 and branch 02 -> FC
    fill();
    imem[0] = 16'h803E;
    BR_COND = 1'b1;
    do_reset();
    repeat (3) cyc();
    chk("t3_to_fe", ADDR, 8'hFE);
    cyc(); chk("t3_ir_fe", IR, 16'h5041);
    cyc(); chk("t3_wrap", ADDR, 8'h00);
    fill();
    imem[1] = 16'hB03C;
    do_reset();
    repeat (5) cyc();
    chk("t3_to_fc", ADDR, 8'hFC);

    // 4: DP_STALL holds EXEC
    fill();
    BR_COND = 1'b0;
    do_reset();
    cyc();
    DP_STALL = 1'b1;
    c0 = commits;
    cyc(); chk("t4_irv1", IR_VALID, 1'b1);
    chk("t4_nocommit", COMMIT, 1'b0);
    BR_COND = 1'b1;
    cyc(); chk("t4_irv2", IR_VALID, 1'b1);
    chk("t4_addr_stall", ADDR, 8'h00);
    cyc(); chk("t4_irv3", IR_VALID, 1'b1);
    cyc(); chk("t4_irv4", IR_VALID, 1'b1);
    chk("t4_commits_stall", commits - c0, 0);
    DP_STALL = 1'b0;
    #1 chk("t4_commit", COMMIT, 1'b1);
    cyc(); chk("t4_irv_off", IR_VALID, 1'b0);
    chk("t4_addr", ADDR, 8'h02);
    chk("t4_commits", commits - c0, 1);
    BR_COND = 1'b0;

    // 5: RUN drops in EXEC; near-HALT encoding must not halt
    fill();
    imem[0] = 16'h0003;
    imem[1] = 16'h1234;
    do_reset();
    cyc();
    cyc(); chk("t5_ir", IR, 16'h0003);
    RUN = 1'b0;
    cyc(); chk("t5_addr", ADDR, 8'h02);
    chk("t5_irv", IR_VALID, 1'b0);
    chk("t5_nohalt", HALTED, 1'b0);
    cyc(); chk("t5_idle_addr", ADDR, 8'h02);
    chk("t5_idle_irv", IR_VALID, 1'b0);
    RUN = 1'b1;
    cyc(); chk("t5_fetch_irv", IR_VALID, 1'b0);
    cyc(); chk("t5_resume_ir", IR, 16'h1234);
    chk("t5_resume_irv", IR_VALID, 1'b1);

    // 6: RESET mid-EXEC
    fill();
    imem[0] = 16'h2222;
    do_reset();
    cyc();
    cyc(); chk("t6_ir_pre", IR, 16'h2222);
    RESET = 1'b1;
    c0 = commits;
    #1 chk("t6_commit_rst", COMMIT, 1'b0);
    cyc(); chk("t6_addr", ADDR, 8'h00);
    chk("t6_ir", IR, 16'h0000);
    chk("t6_irv", IR_VALID, 1'b0);
    chk("t6_commits", commits - c0, 0);
    RESET = 1'b0;
    RUN = 1'b0;
    cyc(); chk("t6_idle_irv", IR_VALID, 1'b0);

`ifdef SINGLE_STEP_EN
    do_reset();
    cyc();
    STEP = 1'b1;
    c0 = commits;
    cyc();
    STEP = 1'b0;
    repeat (6) cyc();
    chk("t6_step_commits", commits - c0, 1);
    chk("t6_step_addr", ADDR, 8'h02);
    chk("t6_step_irv", IR_VALID, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
